// File: rtl/stap_pkg.sv
// Shared constants for the sTAP configuration TAP: state encodings,
// instruction opcodes, IR capture pattern, config bit indices and decode.
package stap_pkg;

  localparam logic [3:0] S_EX2DR   = 4'h0;
  localparam logic [3:0] S_EX1DR   = 4'h1;
  localparam logic [3:0] S_SHDR    = 4'h2;
  localparam logic [3:0] S_PAUSEDR = 4'h3;
  localparam logic [3:0] S_SELIR   = 4'h4;
  localparam logic [3:0] S_UPDDR   = 4'h5;
  localparam logic [3:0] S_CAPDR   = 4'h6;
  localparam logic [3:0] S_SELDR   = 4'h7;
  localparam logic [3:0] S_EX2IR   = 4'h8;
  localparam logic [3:0] S_EX1IR   = 4'h9;
  localparam logic [3:0] S_SHIR    = 4'hA;
  localparam logic [3:0] S_PAUSEIR = 4'hB;
  localparam logic [3:0] S_RTI     = 4'hC;
  localparam logic [3:0] S_UPDIR   = 4'hD;
  localparam logic [3:0] S_CAPIR   = 4'hE;
  localparam logic [3:0] S_TLR     = 4'hF;

  localparam logic [3:0] OP_BYPASS   = 4'hF;
  localparam logic [3:0] OP_IDCODE   = 4'h1;
  localparam logic [3:0] OP_STAP_CFG = 4'h2;
  localparam logic [3:0] OP_STAP_SEL = 4'h3;

  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  localparam int STAP_EN_BIT = 0;
  localparam int BYPASS_BIT  = 1;

  typedef enum logic [1:0] {
    INS_BYPASS,
    INS_IDCODE,
    INS_STAP_CFG,
    INS_STAP_SEL
  } instr_e;

  // Unknown opcodes fall back to BYPASS so the chain always stays one bit long.
  function automatic instr_e decode_ir(input logic [3:0] code);
    case (code)
      OP_IDCODE:   return INS_IDCODE;
      OP_STAP_CFG: return INS_STAP_CFG;
      OP_STAP_SEL: return INS_STAP_SEL;
      default:     return INS_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state 1149.1 TAP controller with one-hot action strobes derived
// directly from the registered state.
module tap_fsm
  import stap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output logic [3:0] state,
  output logic       tlr,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir
);

  logic [3:0] state_nxt;

  // TMS-driven next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_TLR:     state_nxt = tms ? S_TLR     : S_RTI;
      S_RTI:     state_nxt = tms ? S_SELDR   : S_RTI;
      S_SELDR:   state_nxt = tms ? S_SELIR   : S_CAPDR;
      S_CAPDR:   state_nxt = tms ? S_EX1DR   : S_SHDR;
      S_SHDR:    state_nxt = tms ? S_EX1DR   : S_SHDR;
      S_EX1DR:   state_nxt = tms ? S_UPDDR   : S_PAUSEDR;
      S_PAUSEDR: state_nxt = tms ? S_EX2DR   : S_PAUSEDR;
      S_EX2DR:   state_nxt = tms ? S_UPDDR   : S_SHDR;
      S_UPDDR:   state_nxt = tms ? S_SELDR   : S_RTI;
      S_SELIR:   state_nxt = tms ? S_TLR     : S_CAPIR;
      S_CAPIR:   state_nxt = tms ? S_EX1IR   : S_SHIR;
      S_SHIR:    state_nxt = tms ? S_EX1IR   : S_SHIR;
      S_EX1IR:   state_nxt = tms ? S_UPDIR   : S_PAUSEIR;
      S_PAUSEIR: state_nxt = tms ? S_EX2IR   : S_PAUSEIR;
      S_EX2IR:   state_nxt = tms ? S_UPDIR   : S_SHIR;
      S_UPDIR:   state_nxt = tms ? S_SELDR   : S_RTI;
      default:   state_nxt = S_TLR;
    endcase
  end

  // State register; TRST_N forces Test-Logic-Reset without a clock.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= S_TLR;
    else         state <= state_nxt;
  end

  assign tlr    = (state == S_TLR);
  assign cap_dr = (state == S_CAPDR);
  assign sh_dr  = (state == S_SHDR);
  assign upd_dr = (state == S_UPDDR);
  assign cap_ir = (state == S_CAPIR);
  assign sh_ir  = (state == S_SHIR);
  assign upd_ir = (state == S_UPDIR);

endmodule

// File: rtl/stap_config_tap.sv
// TAP front end for the sTAP stage: instruction register, BYPASS/IDCODE/
// STAP_CFG data registers, config_reg, and the negedge TDO mux.
module stap_config_tap
  import stap_pkg::*;
#(
  parameter int                   IR_WIDTH   = 4,
  parameter int                   CFG_WIDTH  = 8,
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001,
  parameter logic [CFG_WIDTH-1:0] CFG_RST    = '0
) (
  input  logic                 TCK,
  input  logic                 TRST_N,
  input  logic                 TMS,
  input  logic                 TDI,
  input  logic                 STDO,
  output logic                 TDO,
  output logic                 TDO_EN,
  output logic [CFG_WIDTH-1:0] config_reg,
  output logic [3:0]           tap_state
);

  logic tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  logic [IR_WIDTH-1:0]  ir;
  logic [IR_WIDTH-1:0]  ir_sh;
  logic                 byp_sh;
  logic [31:0]          id_sh;
  logic [CFG_WIDTH-1:0] cfg_sh;
  logic                 tdo_nxt;
  instr_e               instr;

  tap_fsm u_fsm (
    .tck    (TCK),
    .trst_n (TRST_N),
    .tms    (TMS),
    .state  (tap_state),
    .tlr    (tlr),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .upd_dr (upd_dr),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir)
  );

  assign instr = decode_ir(ir[3:0]);

  // Capture and shift of the IR and DR shift stages; Pause/Exit simply hold.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_sh  <= '0;
      byp_sh <= 1'b0;
      id_sh  <= '0;
      cfg_sh <= '0;
    end else begin
      if (cap_ir)     ir_sh <= IR_WIDTH'(IR_CAPTURE);
      else if (sh_ir) ir_sh <= {TDI, ir_sh[IR_WIDTH-1:1]};

      if (cap_dr) begin
        case (instr)
          INS_IDCODE:   id_sh  <= IDCODE_VAL;
          INS_STAP_CFG: cfg_sh <= config_reg;
          default:      byp_sh <= 1'b0;
        endcase
      end else if (sh_dr) begin
        case (instr)
          INS_IDCODE:   id_sh  <= {TDI, id_sh[31:1]};
          INS_STAP_CFG: cfg_sh <= {TDI, cfg_sh[CFG_WIDTH-1:1]};
          default:      byp_sh <= TDI;
        endcase
      end
    end
  end

  // Instruction and config_reg updates; TLR keeps both pinned to defaults.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir         <= IR_WIDTH'(OP_IDCODE);
      config_reg <= CFG_RST;
    end else if (tlr) begin
      ir         <= IR_WIDTH'(OP_IDCODE);
      config_reg <= CFG_RST;
    end else begin
      if (upd_ir) ir <= ir_sh;
      if (upd_dr && (instr == INS_STAP_CFG)) config_reg <= cfg_sh;
    end
  end

  // Select the serial bit presented on TDO; STAP_SEL forwards the secondary chain.
  always_comb begin
    tdo_nxt = 1'b0;
    if (sh_ir) begin
      tdo_nxt = ir_sh[0];
    end else if (sh_dr) begin
      case (instr)
        INS_IDCODE:   tdo_nxt = id_sh[0];
        INS_STAP_CFG: tdo_nxt = cfg_sh[0];
        INS_STAP_SEL: tdo_nxt = STDO;
        default:      tdo_nxt = byp_sh;
      endcase
    end
  end

  // TDO and its enable launch on the falling edge of TCK.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO    <= tdo_nxt;
      TDO_EN <= sh_ir | sh_dr;
    end
  end

endmodule

// File: tb/tb_stap_config_tap.sv
// Directed and random bench for stap_config_tap against a queue-based TAP model.
module tb_stap_config_tap;
  import stap_pkg::*;

  logic       TCK = 1'b0;
  logic       TRST_N = 1'b1;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       STDO = 1'b0;
  logic       TDO;
  logic       TDO_EN;
  logic [7:0] config_reg;
  logic [3:0] tap_state;

  int n_cmp = 0;
  int n_bad = 0;

  stap_config_tap dut (
    .TCK        (TCK),
    .TRST_N     (TRST_N),
    .TMS        (TMS),
    .TDI        (TDI),
    .STDO       (STDO),
    .TDO        (TDO),
    .TDO_EN     (TDO_EN),
    .config_reg (config_reg),
    .tap_state  (tap_state)
  );

  always #5 TCK = ~TCK;

  // Reference model: transition tables indexed by state code, shift paths as bit queues.
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
  logic [3:0] m_state;
  logic [3:0] m_ir;
  logic [7:0] m_cfg;
  bit         m_dq[$];
  bit         m_iq[$];

  function automatic int m_kind();
    case (m_ir)
      4'h1:    return 1;
      4'h2:    return 2;
      4'h3:    return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_TLR;
    m_ir    = 4'h1;
    m_cfg   = 8'h00;
    m_dq.delete();
    m_iq.delete();
  endtask

  task automatic model_clock(input bit tms, input bit tdi);
    bit drop;
    case (m_state)
      S_TLR: begin m_ir = 4'h1; m_cfg = 8'h00; end
      S_CAPDR: begin
        m_dq.delete();
        if (m_kind() == 1)      for (int i = 0; i < 32; i++) m_dq.push_back(IDCODE_BITS[i]);
        else if (m_kind() == 2) for (int i = 0; i < 8; i++)  m_dq.push_back(m_cfg[i]);
        else                    m_dq.push_back(1'b0);
      end
      S_SHDR: begin drop = m_dq.pop_front(); m_dq.push_back(tdi); end
      S_UPDDR: if (m_kind() == 2) for (int i = 0; i < 8; i++) m_cfg[i] = m_dq[i];
      S_CAPIR: m_iq = '{1'b1, 1'b0, 1'b1, 1'b0};
      S_SHIR: begin drop = m_iq.pop_front(); m_iq.push_back(tdi); end
      S_UPDIR: for (int i = 0; i < 4; i++) m_ir[i] = m_iq[i];
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
  endtask

  logic [31:0] IDCODE_BITS = 32'h1000_0001;

  function automatic bit exp_tdo();
    if (m_state == S_SHIR) return m_iq[0];
    if (m_state == S_SHDR) return (m_kind() == 3) ? STDO : m_dq[0];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  32'(tap_state),  32'(m_state));
    chk({tag, ".cfg"},    32'(config_reg), 32'(m_cfg));
    chk({tag, ".tdo"},    32'(TDO),        32'(exp_tdo()));
    chk({tag, ".tdo_en"}, 32'(TDO_EN),     32'((m_state == S_SHDR) || (m_state == S_SHIR)));
  endtask

  // One TCK: drive before the rising edge, observe just after the falling edge.
  task automatic step(input bit tms, input bit tdi = 1'b0, input bit sd = 1'b0);
    TMS = tms; TDI = tdi; STDO = sd;
    model_clock(tms, tdi);
    @(posedge TCK);
    @(negedge TCK);
    #1;
    check_all("step");
  endtask

  task automatic load_ir(input logic [3:0] code, output logic [3:0] dout);
    dout = '0;
    step(1); step(1); step(0); step(0);
    for (int i = 0; i < 4; i++) begin
      dout[i] = TDO;
      step(i == 3, code[i]);
    end
    step(1); step(0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    step(1); step(0); step(0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      step(i == n - 1, din[i]);
    end
    step(1); step(0);
  endtask

  task automatic async_reset(input string tag);
    TRST_N = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;
    check_all({tag, "_rel"});
  endtask

  initial begin
    logic [3:0]  irout;
    logic [31:0] dout;
    logic [7:0]  pat;
    logic [7:0]  newcfg;

    model_reset();
    #1 TRST_N = 1'b0;
    #2;
    check_all("reset");
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;

    // Five TMS=1 clocks from RTI reach TLR; IDCODE is the default instruction.
    step(0);
    for (int i = 0; i < 5; i++) step(1);
    chk("tlr_after_5", 32'(tap_state), 32'(S_TLR));
    step(0);
    scan_dr(32, 32'h0, dout);
    chk("idcode", dout, 32'h1000_0001);

    // Program config through STAP_CFG, then read it back.
    load_ir(4'h2, irout);
    scan_dr(8, 32'hA5, dout);
    chk("cfg_write", 32'(config_reg), 32'hA5);
    chk("stap_en_bit", 32'(config_reg[STAP_EN_BIT]), 32'h1);
    chk("bypass_bit", 32'(config_reg[BYPASS_BIT]), 32'h0);
    scan_dr(8, 32'hA5, dout);
    chk("cfg_readback", dout, 32'hA5);

    // IR capture pattern, and an undefined opcode behaving as BYPASS.
    load_ir(4'h7, irout);
    chk("ir_capture", 32'(irout), 32'h5);
    scan_dr(8, 32'hB6, dout);
    chk("bypass_delay", dout, 32'h6C);
    chk("cfg_after_bypass", 32'(config_reg), 32'hA5);

    // STAP_SEL forwards STDO on each falling edge.
    load_ir(4'h3, irout);
    pat = 8'b0110_1001;
    step(1); step(0);
    step(0, 1'b0, 1'b1);
    chk("sel_first", 32'(TDO), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(0, $urandom_range(0, 1), pat[i]);
      chk("sel_follow", 32'(TDO), 32'(pat[i]));
    end
    step(1); step(1); step(0);
    chk("cfg_after_sel", 32'(config_reg), 32'hA5);

    // Pause in the middle of a STAP_CFG shift and resume.
    newcfg = 8'h3C;
    load_ir(4'h2, irout);
    step(1); step(0); step(0);
    for (int i = 0; i < 4; i++) step(i == 3, newcfg[i]);
    step(0); step(0); step(0);
    chk("pause_state", 32'(tap_state), 32'(S_PAUSEDR));
    chk("cfg_in_pause", 32'(config_reg), 32'hA5);
    step(1); step(0);
    for (int i = 4; i < 8; i++) step(i == 7, newcfg[i]);
    step(1);
    chk("cfg_at_upd", 32'(config_reg), 32'hA5);
    step(0);
    chk("cfg_resumed", 32'(config_reg), 32'h3C);

    // TRST_N during a shift discards it and clears config at once.
    load_ir(4'h2, irout);
    step(1); step(0); step(0);
    step(0, 1'b1); step(0, 1'b1); step(0, 1'b0);
    async_reset("trst_mid_shift");
    chk("trst_cfg", 32'(config_reg), 32'h00);

    // Random TMS/TDI/STDO walk with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rand_trst");
      else step($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
